// File: rtl/wishbone_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of one shared slave; grants are held for whole cycles.
// Optional stall watchdog with per-master lockout is enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_arbiter #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_BYTES     = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [ADDRESS_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0]    m0_dat_i,
    input  logic                     m0_we_i,
    input  logic [DATA_BYTES-1:0]    m0_sel_i,
    input  logic                     m0_stb_i,
    input  logic                     m0_cyc_i,
    input  logic [2:0]               m0_cti_i,
    output logic [DATA_WIDTH-1:0]    m0_dat_o,
    output logic                     m0_ack_o,
    output logic                     m0_err_o,
    input  logic [ADDRESS_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0]    m1_dat_i,
    input  logic                     m1_we_i,
    input  logic [DATA_BYTES-1:0]    m1_sel_i,
    input  logic                     m1_stb_i,
    input  logic                     m1_cyc_i,
    input  logic [2:0]               m1_cti_i,
    output logic [DATA_WIDTH-1:0]    m1_dat_o,
    output logic                     m1_ack_o,
    output logic                     m1_err_o,
    output logic [ADDRESS_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0]    s_dat_o,
    output logic                     s_we_o,
    output logic [DATA_BYTES-1:0]    s_sel_o,
    output logic                     s_stb_o,
    output logic                     s_cyc_o,
    output logic [2:0]               s_cti_o,
    input  logic [DATA_WIDTH-1:0]    s_dat_i,
    input  logic                     s_ack_i
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   req0, req1;
    logic   timeout;

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       blocked0, blocked1;

    // A master that timed out stays out of arbitration until it ends its cycle.
    assign req0    = m0_cyc_i & ~blocked0;
    assign req1    = m1_cyc_i & ~blocked1;
    assign timeout = (state != IDLE) && (tmo_cnt == 8'(TIMEOUT_CYCLES));

    assign m0_err_o = timeout && (state == GNT0);
    assign m1_err_o = timeout && (state == GNT1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt  <= 8'd0;
            blocked0 <= 1'b0;
            blocked1 <= 1'b0;
        end else begin
            if (state_nxt != state || s_ack_i)
                tmo_cnt <= 8'd0;
            else if (state != IDLE && s_stb_o)
                tmo_cnt <= tmo_cnt + 8'd1;

            if (m0_err_o)
                blocked0 <= 1'b1;
            else if (!m0_cyc_i)
                blocked0 <= 1'b0;

            if (m1_err_o)
                blocked1 <= 1'b1;
            else if (!m1_cyc_i)
                blocked1 <= 1'b0;
        end
    end
`else
    wire [7:0] timeout_unused = 8'(TIMEOUT_CYCLES);

    assign req0     = m0_cyc_i;
    assign req1     = m1_cyc_i;
    assign timeout  = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt == GNT0 && state != GNT0)
                last_grant <= 1'b0;
            else if (state_nxt == GNT1 && state != GNT1)
                last_grant <= 1'b1;
        end
    end

    // Owner keeps the bus for its whole cycle; on release hand straight over if the other is waiting.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last_grant ? GNT0 : GNT1;
                else if (req0)
                    state_nxt = GNT0;
                else if (req1)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if (timeout)
                    state_nxt = IDLE;
                else if (!m0_cyc_i)
                    state_nxt = req1 ? GNT1 : IDLE;
            end
            GNT1: begin
                if (timeout)
                    state_nxt = IDLE;
                else if (!m1_cyc_i)
                    state_nxt = req0 ? GNT0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        s_cti_o = 3'b000;
        case (state)
            GNT0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_stb_o = m0_stb_i;
                s_cyc_o = m0_cyc_i;
                s_cti_o = m0_cti_i;
            end
            GNT1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_stb_o = m1_stb_i;
                s_cyc_o = m1_cyc_i;
                s_cti_o = m1_cti_i;
            end
            default: ;
        endcase
    end

    assign m0_ack_o = (state == GNT0) && s_ack_i;
    assign m1_ack_o = (state == GNT1) && s_ack_i;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: grant latency, round robin, handoff, bursts, timeout, async reset.
module tb_wishbone_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [15:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [7:0]  m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic        m0_we_i, m1_we_i, s_we_o;
    logic [0:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic        m0_stb_i, m1_stb_i, s_stb_o;
    logic        m0_cyc_i, m1_cyc_i, s_cyc_o;
    logic [2:0]  m0_cti_i, m1_cti_i, s_cti_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_ack_i;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    wishbone_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_cti_i(m0_cti_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_cti_i(m1_cti_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_cti_o(s_cti_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 0; m0_sel_i = '0; m0_stb_i = 0; m0_cyc_i = 0; m0_cti_i = '0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 0; m1_sel_i = '0; m1_stb_i = 0; m1_cyc_i = 0; m1_cti_i = '0;
        s_dat_i = '0; s_ack_i = 0;
        #2;
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_stb", s_stb_o, 0);
        chk("rst_s_we", s_we_o, 0);
        chk("rst_m0_ack", m0_ack_o, 0);
        chk("rst_m1_ack", m1_ack_o, 0);
        chk("rst_m0_err", m0_err_o, 0);
        chk("rst_m1_err", m1_err_o, 0);
        #10 rst_ni = 1'b1;

        // single m0 write, one-cycle arbitration latency
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 1; m0_adr_i = 16'h0010; m0_dat_i = 8'hA5;
        #1 chk("wr_lat_idle", s_cyc_o, 0);
        tick();
        chk("wr_s_cyc", s_cyc_o, 1);
        chk("wr_s_adr", s_adr_o, 16'h0010);
        chk("wr_s_dat", s_dat_o, 8'hA5);
        chk("wr_s_we", s_we_o, 1);
        chk("wr_m0_ack_lo", m0_ack_o, 0);
        s_ack_i = 1; s_dat_i = 8'h3C;
        #1;
        chk("wr_m0_ack", m0_ack_o, 1);
        chk("wr_m1_ack", m1_ack_o, 0);
        chk("rd_m0_dat", m0_dat_o, 8'h3C);
        chk("rd_m1_dat", m1_dat_o, 8'h3C);
        tick();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        tick();
        s_ack_i = 1;
        #1 chk("idle_m0_ack", m0_ack_o, 0);
        s_ack_i = 0;

        // simultaneous request right after reset: m0 first, then direct handoff
        #1 rst_ni = 1'b0;
        #2 rst_ni = 1'b1;
        m0_cyc_i = 1; m0_stb_i = 1;
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 16'h0200; m1_dat_i = 8'h5A;
        #1 chk("tie_lat_idle", s_cyc_o, 0);
        tick();
        chk("tie_s_adr_m0", s_adr_o, 16'h0010);
        s_ack_i = 1;
        #1;
        chk("tie_m0_ack", m0_ack_o, 1);
        chk("tie_m1_ack", m1_ack_o, 0);
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        chk("hand_s_adr_m1", s_adr_o, 16'h0200);
        chk("hand_s_cyc", s_cyc_o, 1);
        chk("hand_s_we", s_we_o, 0);
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();

        // 4-beat m1 burst is not split by an m0 request
        m1_cyc_i = 1; m1_stb_i = 1; m1_cti_i = 3'b010; m1_adr_i = 16'h0300;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int i = 0; i < 4; i++) begin
            m1_adr_i = 16'h0300 + 16'(i);
            m1_cti_i = (i == 3) ? 3'b111 : 3'b010;
            s_ack_i = 1;
            #1;
            chk("burst_s_adr", s_adr_o, 16'h0300 + 32'(i));
            chk("burst_s_cti", s_cti_o, (i == 3) ? 3'b111 : 3'b010);
            chk("burst_m1_ack", m1_ack_o, 1);
            chk("burst_m0_ack", m0_ack_o, 0);
            tick();
        end
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_cti_i = 3'b000;
        #1 chk("burst_hold_m1", s_adr_o, 16'h0303);
        tick();
        chk("burst_then_m0", s_adr_o, 16'h0010);
        chk("burst_then_cyc", s_cyc_o, 1);
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        // m0 stalls: err pulse after 15 stalled cycles, m1 served, m0 locked out until cyc drops
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h0200;
        for (int i = 0; i < 15; i++) begin
            chk("tmo_err_early", m0_err_o, 0);
            tick();
        end
        chk("tmo_m0_err", m0_err_o, 1);
        chk("tmo_m1_err", m1_err_o, 0);
        tick();
        chk("tmo_err_pulse", m0_err_o, 0);
        chk("tmo_idle", s_cyc_o, 0);
        tick();
        chk("tmo_m1_gnt", s_adr_o, 16'h0200);
        chk("tmo_m1_cyc", s_cyc_o, 1);
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        chk("tmo_m0_blocked", s_cyc_o, 0);
        tick();
        chk("tmo_m0_blocked2", s_cyc_o, 0);
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        chk("tmo_m0_regnt", s_cyc_o, 1);
        chk("tmo_m0_regnt_adr", s_adr_o, 16'h0010);
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
`else
        // no watchdog: a stalled grant is held and err never fires
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        repeat (20) tick();
        chk("hold_m0_err", m0_err_o, 0);
        chk("hold_s_cyc", s_cyc_o, 1);
        chk("hold_s_adr", s_adr_o, 16'h0010);
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
`endif

        // async reset during an m1 transfer
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h0400;
        tick();
        chk("ar_gnt", s_cyc_o, 1);
        s_ack_i = 1;
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_s_cyc", s_cyc_o, 0);
        chk("ar_s_stb", s_stb_o, 0);
        chk("ar_m1_ack", m1_ack_o, 0);
        chk("ar_m1_err", m1_err_o, 0);
        #2 rst_ni = 1'b1;
        s_ack_i = 0;
        #1 chk("ar_post_idle", s_cyc_o, 0);
        tick();
        chk("ar_regnt_cyc", s_cyc_o, 1);
        chk("ar_regnt_adr", s_adr_o, 16'h0400);
        chk("ar_m0_ack", m0_ack_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
